// File: rtl/gain_mixer.sv
// Time-multiplexed N-channel offset-binary mixer with per-channel 8-bit gain.
// Define MIXER_SATURATE_EN to clamp the result instead of wrapping it.
module gain_mixer #(
  parameter int unsigned BITDEPTH = 14,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_clock,
  input  logic [CHANNELS*BITDEPTH-1:0] pcm_in,
  input  logic [CHANNELS*8-1:0]        gain,
  output logic [BITDEPTH-1:0]          mix,
  output logic                         mix_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int unsigned IDXW  = $clog2(CHANNELS);
  localparam int unsigned PRODW = BITDEPTH + 9;
  localparam int unsigned ACCW  = PRODW + IDXW;
  localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(CHANNELS - 1);
  localparam logic [BITDEPTH-1:0] MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t                 state, state_next;
  logic                   sc_q, inhibit, trigger;
  logic                   snap_en, acc_en, out_en;
  logic [BITDEPTH-1:0]    pcm_snap  [CHANNELS];
  logic [7:0]             gain_snap [CHANNELS];
  logic [IDXW-1:0]        idx;
  logic signed [ACCW-1:0] acc;
  logic [BITDEPTH-1:0]    s_raw;
  logic signed [PRODW-1:0] s_ext, g_ext, prod;
  logic [BITDEPTH-1:0]    r_lim;

  // The inhibit flag lets sc_q pick up a sample_clock that is already high at
  // reset release, so a level held through reset never looks like an edge.
  assign trigger = sample_clock & ~sc_q & ~inhibit;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    snap_en    = 1'b0;
    acc_en     = 1'b0;
    out_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          snap_en    = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        acc_en = 1'b1;
        if (idx == LAST_IDX) state_next = OUT;
      end
      OUT: begin
        out_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (snap_en) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pcm_snap[i]  <= pcm_in[i*BITDEPTH +: BITDEPTH];
        gain_snap[i] <= gain[i*8 +: 8];
      end
    end
  end

  // Offset-binary to two's complement, times the zero-extended unsigned gain.
  always_comb begin
    s_raw = pcm_snap[idx];
    s_ext = {{9{~s_raw[BITDEPTH-1]}}, ~s_raw[BITDEPTH-1], s_raw[BITDEPTH-2:0]};
    g_ext = {{(BITDEPTH+1){1'b0}}, gain_snap[idx]};
    prod  = s_ext * g_ext;
  end

`ifdef MIXER_SATURATE_EN
  localparam logic signed [ACCW-1:0] R_MAX = ACCW'((2**(BITDEPTH-1)) - 1);
  localparam logic signed [ACCW-1:0] R_MIN = ~R_MAX;
  logic signed [ACCW-1:0] r;

  always_comb begin
    r = acc >>> 7;
    if (r > R_MAX)      r_lim = R_MAX[BITDEPTH-1:0];
    else if (r < R_MIN) r_lim = R_MIN[BITDEPTH-1:0];
    else                r_lim = r[BITDEPTH-1:0];
  end
`else
  assign r_lim = acc[BITDEPTH+6:7];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_q      <= 1'b0;
      inhibit   <= 1'b1;
      acc       <= '0;
      idx       <= '0;
      mix       <= MIDSCALE;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sc_q      <= sample_clock;
      inhibit   <= 1'b0;
      mix_valid <= out_en;
      overrun   <= trigger & (state != IDLE);
      if (snap_en) begin
        acc <= '0;
        idx <= '0;
      end else if (acc_en) begin
        acc <= acc + {{IDXW{prod[PRODW-1]}}, prod};
        idx <= idx + IDXW'(1);
      end
      if (out_en) mix <= {~r_lim[BITDEPTH-1], r_lim[BITDEPTH-2:0]};
    end
  end

endmodule

// File: tb/tb_gain_mixer.sv
// Directed self-checking bench for gain_mixer (BITDEPTH=14, CHANNELS=4).
module tb_gain_mixer;

  localparam int BD = 14;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_clock;
  logic [CH*BD-1:0] pcm_in;
  logic [CH*8-1:0] gain;
  logic [BD-1:0]   mix;
  logic            mix_valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount, bcount;

  gain_mixer #(.BITDEPTH(BD), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .sample_clock(sample_clock),
    .pcm_in(pcm_in), .gain(gain),
    .mix(mix), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic set_inputs(input logic [BD-1:0] p0, input logic [BD-1:0] p_rest,
                            input logic [7:0] g0, input logic [7:0] g_rest);
    pcm_in = {p_rest, p_rest, p_rest, p0};
    gain   = {g_rest, g_rest, g_rest, g0};
  endtask

  // k counts negedges after trigger edge E; values seen at k follow edge E+k.
  task automatic run_mix(input string tag, input int exp_mix, input bit do_ovr, input bit change_pcm);
    logic [15:0] bpat, vpat, opat;
    bpat = '0; vpat = '0; opat = '0;
    @(negedge clk);
    sample_clock = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bpat[k] = busy;
      vpat[k] = mix_valid;
      opat[k] = overrun;
      if (change_pcm && k == 0) pcm_in = ~pcm_in;
      if (do_ovr && k == 0) sample_clock = 1'b0;
      if (do_ovr && k == 1) sample_clock = 1'b1;
      if (k == 3) sample_clock = 1'b0;
    end
    check_val({tag, "_busy"},    32'(bpat), 32'h001F);
    check_val({tag, "_valid"},   32'(vpat), 32'h0020);
    check_val({tag, "_overrun"}, 32'(opat), do_ovr ? 32'h0004 : 32'h0);
    check_val({tag, "_mix"},     32'(mix),  32'(exp_mix));
  endtask

  initial begin
    rst = 1'b0;
    sample_clock = 1'b1;
    set_inputs(14'd8192, 14'd8192, 8'h80, 8'h80);
    repeat (3) @(negedge clk);
    check_val("rst_mix",       32'(mix),       32'd8192);
    check_val("rst_mix_valid", 32'(mix_valid), 32'd0);
    check_val("rst_busy",      32'(busy),      32'd0);
    check_val("rst_overrun",   32'(overrun),   32'd0);

    rst = 1'b1;
    vcount = 0; bcount = 0;
    repeat (10) begin
      @(negedge clk);
      vcount += int'(mix_valid);
      bcount += int'(busy);
    end
    check_val("release_high_valid", 32'(vcount), 32'd0);
    check_val("release_high_busy",  32'(bcount), 32'd0);
    sample_clock = 1'b0;
    @(negedge clk);

    run_mix("silence", 8192, 1'b0, 1'b0);

    set_inputs(14'd12288, 14'd8192, 8'h80, 8'h80);
    run_mix("gain_unity", 12288, 1'b0, 1'b0);
    set_inputs(14'd12288, 14'd8192, 8'h40, 8'h80);
    run_mix("gain_half", 10240, 1'b0, 1'b0);
    set_inputs(14'd12288, 14'd8192, 8'h00, 8'h80);
    run_mix("gain_mute", 8192, 1'b0, 1'b0);

    set_inputs(14'd16383, 14'd16383, 8'h80, 8'h80);
`ifdef MIXER_SATURATE_EN
    run_mix("overflow", 16383, 1'b0, 1'b0);
`else
    run_mix("overflow", 8188, 1'b0, 1'b0);
`endif

    set_inputs(14'd12288, 14'd8192, 8'h80, 8'h80);
    run_mix("ovr_snap", 12288, 1'b1, 1'b1);

    // Mid-mix reset: previous mix is 12288, new mix would be 10240.
    set_inputs(14'd12288, 14'd8192, 8'h40, 8'h80);
    @(negedge clk);
    sample_clock = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_mix",   32'(mix),       32'd8192);
    check_val("midrst_busy",  32'(busy),      32'd0);
    check_val("midrst_valid", 32'(mix_valid), 32'd0);
    sample_clock = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    vcount = 0;
    repeat (10) begin
      @(negedge clk);
      vcount += int'(mix_valid);
    end
    check_val("midrst_no_valid", 32'(vcount), 32'd0);
    check_val("midrst_mix_held", 32'(mix),    32'd8192);
    run_mix("after_rst", 10240, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gain_mixer.md
# gain_mixer

Parametrised, time-multiplexed N-channel audio mixer with per-channel 8-bit gain, the successor to the fixed four-input mixer. It sits between the voice bank and the DAC. On every rising edge of the sample strobe it snapshots all channel samples and gains, accumulates them serially over CHANNELS clock cycles, and registers one mixed PCM word, so channel count scales without a wide adder tree.

## Interface
- BITDEPTH, 14: sample width; inputs and output are offset-binary, with midscale at 2^(BITDEPTH-1).
- CHANNELS, 4: number of mixed channels, 2..32.
- clk  in  1  system clock, 8 MHz in current builds.
- rst  in  1  asynchronous, active-low reset.
- sample_clock  in  1  divided sample strobe, synchronous to clk; only its rising edge matters.
- pcm_in  in  CHANNELS*BITDEPTH  channel i occupies bits [i*BITDEPTH +: BITDEPTH].
- gain  in  CHANNELS*8  channel i gain occupies bits [i*8 +: 8]; unsigned; 0x80 = unity, 0x00 = mute, 0xFF ≈ 1.99.
- mix  out  BITDEPTH  mixed sample, offset-binary; held between updates.
- mix_valid  out  1  one-cycle pulse when mix updates.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  one-cycle pulse when a trigger arrives while busy.

## Operation
- Trigger: register sample_clock as sc_q. Trigger = sample_clock & ~sc_q.
- FSM states:
  - IDLE: on trigger, snapshot pcm_in and gain into internal registers, clear the accumulator, set idx=0, and go to ACCUM.
  - ACCUM: add the product for channel idx, then idx++. After idx = CHANNELS-1, go to OUT.
  - OUT: write mix, pulse mix_valid, and return to IDLE.
- Arithmetic, per channel:
  - s = pcm with the MSB inverted, treated as signed BITDEPTH.
  - p = s * {1'b0, gain}, signed BITDEPTH+9.
  - The accumulator is signed BITDEPTH+9+clog2(CHANNELS), so it never overflows.
  - Result r = acc >>> 7 (arithmetic shift).
  - r is limited to BITDEPTH signed (see Configuration).
  - mix = r with the MSB inverted.
- Inputs are used only from the snapshot; changes to pcm_in or gain during ACCUM do not affect the current mix.
- A trigger in any state other than IDLE is ignored and pulses overrun for exactly one cycle. The mix in progress completes unchanged.
- busy = (state != IDLE).

## Timing
- Let E be the clk edge at which the trigger is true.
  - Snapshot is taken at E.
  - Accumulation happens at edges E+1..E+CHANNELS.
  - mix and mix_valid are registered at E+CHANNELS+1.
- Latency from trigger to mix_valid is CHANNELS+1 cycles.
- busy is high from after E through the E+CHANNELS+1 edge.
- Minimum sample_clock period is CHANNELS+2 clk cycles. The current divider gives 256 cycles.
- Reset values, applied immediately on rst low regardless of clk:
  - mix = 2^(BITDEPTH-1) (midscale, 0x2000 at 14 bits)
  - mix_valid = 0, busy = 0, overrun = 0
  - state = IDLE, sc_q = 0
- Reset mid-mix aborts the mix with no mix_valid pulse.
- Release of reset while sample_clock is already high does not trigger, because sc_q is cleared and a rising edge is required. Note the implication: sc_q=0 with sample_clock=1 on the first clock after release would look like an edge. Therefore sc_q must load sample_clock during the first clock after release without triggering; a single-cycle post-reset inhibit flag implements this.

## Configuration
- MIXER_SATURATE_EN:
  - Defined: r is clamped to [-2^(BITDEPTH-1), 2^(BITDEPTH-1)-1] before the MSB inversion.
  - Undefined: r is truncated to its low BITDEPTH bits (two's-complement wrap), and the clamp logic is absent.

## Test plan
All scenarios use BITDEPTH=14, CHANNELS=4.
- Reset: hold rst low → mix=8192, mix_valid=0, busy=0, overrun=0. Release rst with sample_clock high → no mix_valid until the next rising edge.
- Silence: all pcm=8192, all gain=0x80, trigger at E → mix=8192, mix_valid pulse exactly at E+5, busy high E..E+5.
- Gain: ch0 pcm=12288 with gain 0x80, others midscale → mix=12288. Same with ch0 gain 0x40 → mix=10240. ch0 gain 0x00 → mix=8192.
- Overflow: all pcm=16383, gain 0x80 (sum r=32764) → with MIXER_SATURATE_EN mix=16383; without it mix=8188.
- Overrun/snapshot: second trigger at E+2 → overrun pulses once, no extra mix_valid. Change pcm_in at E+1 → the mix reflects the values snapshotted at E.
- Mid-mix reset: rst low at E+2 → mix=8192 immediately, busy=0, no mix_valid. A normal mix succeeds on the next trigger.
